// File: rtl/core_clk_pkg.sv
// Shared types and default timing constants for the core clock/reset controller.
package core_clk_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } clk_state_t;

  localparam int DEF_RST_HOLD = 2**25;
  localparam int DEF_DEBOUNCE = 500000;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter for an active-low push-button.
// Emits the debounced level and a one-cycle pulse on each accepted press.
module key_debouncer
  import core_clk_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A new level is taken only after DEBOUNCE consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_clock_ctrl.sv
// Single-domain clock-enable and reset controller for the CPU core: divided
// run strobe, stretched reset, debounced single-step and sticky breakpoint halt.
module core_clock_ctrl
  import core_clk_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int NUM_RST_SRC = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk50,
  input  logic                   rst,
  input  logic [NUM_RST_SRC-1:0] rst_req,
  input  logic                   run_en,
  input  logic [DIV_W-1:0]       div,
  input  logic                   step_key_n,
  input  logic                   brk,
  input  logic                   resume,
  output logic                   core_en,
  output logic                   core_rst,
  output logic                   halted,
  output logic [CNT_W-1:0]       tick_count
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  clk_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic              brk_latched, brk_nxt;
  logic              en_nxt;
  logic              src;
  logic              key_level, key_press, step_req;

  key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step (
    .clk   (clk50),
    .rst   (rst),
    .key_n (step_key_n),
    .level (key_level),
    .press (key_press)
  );

  assign src      = |rst_req;
  // Press pulse is honoured only while the filtered key still reads pressed.
  assign step_req = key_press & ~key_level;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) state <= RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET:   if (hold_cnt == '0) state_nxt = run_en ? RUN : HALT;
      RUN:     if (brk || !run_en) state_nxt = HALT;
      HALT:    if (run_en && !brk_nxt) state_nxt = RUN;
      default: state_nxt = RESET;
    endcase
    if (src) state_nxt = RESET;
  end

  // brk outranks both the divider match and a same-cycle resume.
  always_comb begin
    en_nxt      = 1'b0;
    div_cnt_nxt = '0;
    brk_nxt     = 1'b0;
    case (state)
      RUN: begin
        brk_nxt = brk;
        if (div_cnt >= div) en_nxt = ~brk & run_en;
        else                div_cnt_nxt = div_cnt + 1'b1;
      end
      HALT: begin
        brk_nxt = brk | (brk_latched & ~resume);
        en_nxt  = step_req;
      end
      default: ;
    endcase
    if (src) en_nxt = 1'b0;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      hold_cnt    <= HOLD_W'(RST_HOLD);
      div_cnt     <= '0;
      brk_latched <= 1'b0;
      core_en     <= 1'b0;
      core_rst    <= 1'b1;
      halted      <= 1'b0;
      tick_count  <= '0;
    end else begin
      if (src)                 hold_cnt <= HOLD_W'(RST_HOLD);
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      div_cnt     <= div_cnt_nxt;
      brk_latched <= brk_nxt;
      core_en     <= en_nxt;
      core_rst    <= (state_nxt == RESET);
      halted      <= (state_nxt == HALT);
      if (state_nxt == RESET) tick_count <= '0;
      else if (en_nxt)        tick_count <= tick_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Scoreboarded directed bench: stimulus queues predicted core_en pulses,
// a negedge monitor matches each observed pulse against the queue.
module tb_core_clock_ctrl;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic        clk50 = 1'b0;
  logic        rst;
  logic [1:0]  rst_req, rst_req2;
  logic        run_en;
  logic [7:0]  div;
  logic        step_key_n;
  logic        brk, resume;
  logic        core_en, core_rst, halted;
  logic [15:0] tick_count;
  logic        core_en2, core_rst2, halted2;
  logic [3:0]  tick_count2;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   r = 0;
  logic wrap_done = 1'b0;
  exp_t q[$];

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  core_clock_ctrl #(.DIV_W(8), .RST_HOLD(8), .DEBOUNCE(4), .NUM_RST_SRC(2), .CNT_W(16)) dut (
    .clk50(clk50), .rst(rst), .rst_req(rst_req), .run_en(run_en), .div(div),
    .step_key_n(step_key_n), .brk(brk), .resume(resume),
    .core_en(core_en), .core_rst(core_rst), .halted(halted), .tick_count(tick_count)
  );

  core_clock_ctrl #(.DIV_W(8), .RST_HOLD(8), .DEBOUNCE(4), .NUM_RST_SRC(2), .CNT_W(4)) dut_wrap (
    .clk50(clk50), .rst(rst), .rst_req(rst_req2), .run_en(1'b1), .div(8'd0),
    .step_key_n(1'b1), .brk(1'b0), .resume(1'b0),
    .core_en(core_en2), .core_rst(core_rst2), .halted(halted2), .tick_count(tick_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic go(input int e);
    while (cyc < e) begin
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic push_ticks(input int first, input int period, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      e.cyc = first + i * period;
      e.cnt = exp_cnt;
      q.push_back(e);
    end
  endtask

  // Monitor: every observed strobe must match the next predicted one.
  always @(negedge clk50) begin
    if (core_en === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_en: got pulse at cycle %0d tick_count %0d want none", cyc, tick_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc != e.cyc || 32'(tick_count) != e.cnt) begin
          bad++;
          $display("FAIL en_pulse: got cycle %0d count %0d want cycle %0d count %0d",
                   cyc, tick_count, e.cyc, e.cnt);
        end
      end
    end
  end

  initial begin : wrap_chk
    int n2;
    n2 = 0;
    forever begin
      @(negedge clk50);
      if (core_en2 === 1'b1) begin
        n2++;
        if (n2 == 17) begin
          chk("wrap_count", 32'(tick_count2), 32'd1);
          chk("wrap_cycle", cyc, r + 26);
          wrap_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, p, u;
    rst = 1'b1; rst_req = '0; rst_req2 = '0; run_en = 1'b1; div = 8'd3;
    step_key_n = 1'b1; brk = 1'b0; resume = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_core_en", 32'(core_en), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_tick", 32'(tick_count), 0);
    r = cyc;
    rst = 1'b0;

    // power-on stretch and div=3 run
    push_ticks(r + 13, 4, 3);
    go(r + 8);  chk("hold_last", 32'(core_rst), 1);
    go(r + 9);  chk("hold_fall", 32'(core_rst), 0);
    chk("run_not_halted", 32'(halted), 0);

    // divider lowered 7 -> 1 while div_cnt = 5
    t0 = r + 21;
    go(t0);     div = 8'd7;
    go(t0 + 5); div = 8'd1;
    push_ticks(t0 + 6, 2, 3);

    // breakpoint on a match cycle
    go(t0 + 11); brk = 1'b1;
    go(t0 + 12); brk = 1'b0;
    chk("brk_halted", 32'(halted), 1);
    chk("brk_no_en", 32'(core_en), 0);
    chk("brk_tick_kept", 32'(tick_count), 6);
    go(t0 + 15); brk = 1'b1; resume = 1'b1;
    go(t0 + 16); brk = 1'b0; resume = 1'b0;
    chk("brk_wins", 32'(halted), 1);
    go(t0 + 18); chk("latch_held", 32'(halted), 1);
    resume = 1'b1;
    go(t0 + 19); resume = 1'b0;
    chk("resume_run", 32'(halted), 0);
    push_ticks(t0 + 21, 2, 2);
    go(t0 + 23); run_en = 1'b0;
    go(t0 + 24); chk("step_mode_halt", 32'(halted), 1);

    // bouncy press in HALT: three 1-cycle glitches then held 10 cycles
    s = t0 + 26;
    go(s);
    for (int i = 0; i < 6; i++) begin
      step_key_n = (i % 2 == 1);
      go(s + i + 1);
    end
    p = s + 6;
    step_key_n = 1'b0;
    push_ticks(p + 7, 1, 1);
    go(p + 10); step_key_n = 1'b1;

    // press during RUN must be dropped
    go(p + 20); run_en = 1'b1;
    push_ticks(p + 23, 2, 9);
    go(p + 22); step_key_n = 1'b0;
    go(p + 32); step_key_n = 1'b1;
    go(p + 40); run_en = 1'b0;
    go(p + 41); chk("run_to_halt", 32'(halted), 1);
    go(p + 60); chk("no_queued_step", 32'(tick_count), 18);

    // run to 0xFFFF then abort with rst_req[1]
    u = p + 60;
    run_en = 1'b1; div = 8'd0;
    push_ticks(u + 2, 1, 65517);
    go(u + 65518);
    chk("tick_at_max", 32'(tick_count), 32'hFFFF);
    rst_req = 2'b10;
    go(u + 65519);
    rst_req = 2'b00;
    chk("req_core_rst", 32'(core_rst), 1);
    chk("req_core_en", 32'(core_en), 0);
    chk("req_tick_clr", 32'(tick_count), 0);
    go(u + 65527); chk("req_hold_last", 32'(core_rst), 1);
    go(u + 65528); chk("req_hold_fall", 32'(core_rst), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk50);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    chk("wrap_seen", 32'(wrap_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_clock_ctrl.md
# core_clock_ctrl

Parametrised clock-enable and reset controller for the CPU core. It replaces the divided-clock and toggle-register clocking in the top level with a single-clock-domain design. It produces a one-cycle `core_en` strobe at a programmable divide ratio, stretched power/key/software reset, debounced single-step from a push-button, and a sticky breakpoint halt with explicit resume. It sits between board I/O (keys, switches) and the `cpu` instance, running entirely on `clk50`.

## Interface
- `DIV_W`, 8: width of the divide-ratio input.
- `RST_HOLD`, 2**25: cycles `core_rst` stays high after the last reset source deasserts.
- `DEBOUNCE`, 500000: cycles the step key must be stable before a level change is accepted.
- `NUM_RST_SRC`, 2: number of synchronous reset-request inputs.
- `CNT_W`, 16: width of `tick_count`.

Ports:
- `clk50` in 1: 50 MHz clock.
- `rst` in 1: asynchronous, active-high reset (power-on/board).
- `rst_req` in `NUM_RST_SRC`: synchronous reset requests (reset key, CPU `rstReq`). Each is active-high and level.
- `run_en` in 1: 1 = free-run mode, 0 = manual step mode (SW[0]).
- `div` in `DIV_W`: a core tick occurs every `div+1` cycles in RUN.
- `step_key_n` in 1: raw asynchronous push-button, active-low.
- `brk` in 1: breakpoint request from the core, level.
- `resume` in 1: single-cycle pulse that clears a latched breakpoint.
- `core_en` out 1: one-cycle clock enable for the core.
- `core_rst` out 1: synchronous reset to the core.
- `halted` out 1: high in HALT state.
- `tick_count` out `CNT_W`: number of `core_en` pulses since `core_rst` fell; wraps modulo 2^`CNT_W`.

## Operation
- **States:** RESET, RUN, HALT.
  - On `rst` (async), on any `rst_req` bit, or while the hold counter is nonzero: state is RESET, `core_rst`=1, `core_en`=0.
  - The hold counter reloads to `RST_HOLD` every cycle any source is active and decrements otherwise.
- **RESET exit:** when the hold counter reaches 0, the next cycle enters RUN if `run_en`=1, else HALT. `brk_latched` is cleared and `div_cnt` is 0.
- **RUN:**
  - `div_cnt` increments each cycle.
  - When `div_cnt >= div`, `core_en`=1 and `div_cnt` clears. Lowering `div` mid-count therefore ticks on the next cycle; it never stalls.
  - `brk`=1 sets `brk_latched` and moves to HALT the same edge. No `core_en` is issued on that cycle, even if the divider matched.
  - `run_en`=0 moves to HALT with no tick.
- **HALT:**
  - `halted`=1.
  - A debounced step press issues exactly one `core_en` pulse, ignoring `div`.
  - Transition to RUN requires `run_en`=1 and `brk_latched`=0, with `div_cnt` cleared on entry.
  - `resume` clears `brk_latched`.
  - Simultaneous `brk` and `resume`: `brk` wins and the latch stays set.
- **Step key path:** 2-flop synchroniser, then a debouncer.
  - A debounced falling edge (press) yields one step request pulse.
  - A press while in RUN or RESET is discarded, not queued.
- **tick_count:** increments on every `core_en`, is held at 0 while `core_rst`=1, and wraps 2^`CNT_W`−1 → 0.

## Timing
- **Reset values (asynchronous):**
  - `core_rst`=1, `core_en`=0, `halted`=0, `tick_count`=0.
  - State RESET, hold counter=`RST_HOLD`.
  - Debounced key level=1 (released), synchroniser flops=1.
- **All outputs are registered.**
- **RESET latency:**
  - `core_rst` rises 1 cycle after a `rst_req` bit is sampled high.
  - It falls exactly `RST_HOLD`+1 cycles after the last cycle any source was high.
  - A `rst_req` asserted mid-RUN aborts immediately: `core_en` is 0 from the next cycle.
- **Divider:** with a constant `div`=N, `core_en` has a period of N+1 cycles. The first pulse comes N+1 cycles after entering RUN.
- **Step latency:** 2 sync cycles + `DEBOUNCE` stable cycles + 1 cycle to `core_en`. Key bounce shorter than `DEBOUNCE` produces no pulse.
- **Breakpoint:** `brk` sampled at edge k gives `halted`=1 and `core_en`=0 from k+1.
- **Resume:** `resume` at edge k with `run_en`=1 gives RUN at k+1. The first tick follows at k+1+`div`+1.

## Structure
- **Package `core_clk_pkg`:** holds the state enum `clk_state_t` {RESET, RUN, HALT} and default parameter constants (`DEF_RST_HOLD`, `DEF_DEBOUNCE`).
- **Sub-module `key_debouncer`:** parametrised by `DEBOUNCE`. Contains the synchroniser and stability counter, and outputs the debounced level and a press pulse. It is reusable for KEY[0] reset conditioning in the top level.
- The remaining logic (state register, hold counter, divider, tick counter) stays in `core_clock_ctrl`.

## Test plan
Bench parameters: `RST_HOLD`=8, `DEBOUNCE`=4.

- **Power-on reset:** `rst` pulse → `core_rst`=1 for 9 cycles after release. With `run_en`=1 and `div`=3, the first `core_en` arrives 4 cycles after RUN entry, then every 4 cycles.
- **Divider change:** `div` changes 7→1 while `div_cnt`=5 → `core_en` on the next cycle, then a period of 2.
- **Breakpoint:**
  - `brk` asserted on a divider-match cycle → no `core_en`, `halted`=1, `tick_count` unchanged.
  - `brk`+`resume` in the same cycle → stays halted.
  - `resume` alone → RUN, with a tick after `div`+1 cycles.
- **Step mode:**
  - `run_en`=0, key pressed with 3-cycle bounce glitches then held 10 cycles → exactly one `core_en`.
  - Press during RUN → no extra pulse.
- **Reset mid-run:** `rst_req[1]` pulsed for 1 cycle while `tick_count`=0xFFFF → `core_en` stops next cycle, `tick_count`=0, `core_rst` high for 9 cycles.
- **Wrap:** `CNT_W`=4, 17 ticks → `tick_count`=1.
